// File: rtl/task_11_pkg.sv
// Shared types and constants for the task-11 output stage.
package task_11_pkg;

  localparam int unsigned DEF_DATA_WIDTH  = 8;
  localparam int unsigned OUT_ENTRY_WIDTH = DEF_DATA_WIDTH + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_RUN,
    S_TRAILER,
    S_DRAIN,
    S_DONE
  } task_11_out_enum;

  // FIFO entry is {last, data}
  function automatic int unsigned entry_width(input int unsigned data_width);
    return data_width + 1;
  endfunction

endpackage

// File: rtl/task_11_out_if.sv
// Byte stream with tlast and valid/ready handshake leaving the task-11 output stage.
interface task_11_out_if
  import task_11_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
);
  logic [DATA_WIDTH-1:0] o_tdata;
  logic                  o_tdata_valid;
  logic                  o_tdata_last;
  logic                  i_tready;

  modport master (output o_tdata, o_tdata_valid, o_tdata_last, input  i_tready);
  modport slave  (input  o_tdata, o_tdata_valid, o_tdata_last, output i_tready);
endinterface

// File: rtl/task_11_out_fifo.sv
// Show-ahead synchronous FIFO; head entry visible on dout while not empty.
module task_11_out_fifo
  import task_11_pkg::*;
#(
  parameter int unsigned WIDTH = OUT_ENTRY_WIDTH,
  parameter int unsigned DEPTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);
  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot, so a push into a full FIFO still lands
  assign do_push = push & (~full | do_pop);
  assign dout    = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge i_clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/task_11_out.sv
// Two-phase counter/latch emulation driven by loader clock patterns; captures
// latch values into a byte stream and signals when each burst has drained.
module task_11_out
  import task_11_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned OUT_DEPTH  = 16
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_clk_1,
  input  logic               i_clk_2,
  input  logic               i_clk_sampl,
  input  logic               i_enb,
  task_11_out_if.master      out_if,
  output logic               o_output_last,
  output logic               o_overflow
);
  localparam int unsigned EW = entry_width(DATA_WIDTH);

  task_11_out_enum       state, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [DATA_WIDTH-1:0] a_base, b_base, b_new;
  logic                  p1_q, p1_d, p2_q, p2_d, ps_q, ps_d;
  logic                  first, sample, rise1, rise2, rises;
  logic                  ovf_set;
  logic                  push, pop, can_push, full, empty;
  logic [EW-1:0]         din, dout;

  task_11_out_fifo #(
    .WIDTH (EW),
    .DEPTH (OUT_DEPTH)
  ) u_fifo (
    .i_clk (i_clk),
    .i_rst (i_rst),
    .push  (push),
    .pop   (pop),
    .din   (din),
    .dout  (dout),
    .full  (full),
    .empty (empty)
  );

  assign out_if.o_tdata_valid = ~empty;
  assign out_if.o_tdata       = empty ? '0 : dout[DATA_WIDTH-1:0];
  assign out_if.o_tdata_last  = ~empty & dout[DATA_WIDTH];
  assign pop                  = ~empty & out_if.i_tready;
  assign can_push             = ~full | pop;
  assign o_output_last        = (state == S_DONE);

  // The first sample of a burst sees cleared A/B/previous bits without an extra idle cycle
  assign first  = (state == S_IDLE);
  assign sample = i_enb & ((state == S_IDLE) | (state == S_RUN));
  assign a_base = first ? '0 : a_q;
  assign b_base = first ? '0 : b_q;
  assign rise1  = i_clk_1     & ~(p1_q & ~first);
  assign rise2  = i_clk_2     & ~(p2_q & ~first);
  assign rises  = i_clk_sampl & ~(ps_q & ~first);
  assign b_new  = rise2 ? a_base : b_base;

  always_comb begin
    state_d = state;
    a_d     = a_q;
    b_d     = b_q;
    p1_d    = p1_q;
    p2_d    = p2_q;
    ps_d    = ps_q;
    push    = 1'b0;
    din     = '0;
    ovf_set = 1'b0;

    if (sample) begin
      a_d  = a_base + DATA_WIDTH'(rise1);
      b_d  = b_new;
      p1_d = i_clk_1;
      p2_d = i_clk_2;
      ps_d = i_clk_sampl;
      if (rises) begin
        if (can_push) begin
          push = 1'b1;
          din  = {1'b0, b_new};
        end else begin
          ovf_set = 1'b1;
        end
      end
    end else if (i_enb) begin
      ovf_set = 1'b1;
    end

    case (state)
      S_IDLE:    if (i_enb) state_d = S_RUN;
      S_RUN:     if (!i_enb) state_d = S_TRAILER;
      S_TRAILER: begin
        if (can_push) begin
          push    = 1'b1;
          din     = {1'b1, a_q};
          state_d = S_DRAIN;
        end
      end
      S_DRAIN:   if (pop && dout[DATA_WIDTH]) state_d = S_DONE;
      S_DONE:    state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state      <= S_IDLE;
      a_q        <= '0;
      b_q        <= '0;
      p1_q       <= 1'b0;
      p2_q       <= 1'b0;
      ps_q       <= 1'b0;
      o_overflow <= 1'b0;
    end else begin
      state      <= state_d;
      a_q        <= a_d;
      b_q        <= b_d;
      p1_q       <= p1_d;
      p2_q       <= p2_d;
      ps_q       <= ps_d;
      o_overflow <= o_overflow | ovf_set;
    end
  end

endmodule

// File: tb/tb_task_11_out.sv
// Directed bench for task_11_out: bursts with hand-computed byte streams.
module tb_task_11_out;
  localparam int DW    = 8;
  localparam int DEPTH = 16;

  logic i_clk = 1'b0;
  logic i_rst = 1'b1;
  logic i_clk_1 = 1'b0, i_clk_2 = 1'b0, i_clk_sampl = 1'b0, i_enb = 1'b0;
  logic o_output_last, o_overflow;

  task_11_out_if #(.DATA_WIDTH(DW)) out_if ();

  task_11_out #(.DATA_WIDTH(DW), .OUT_DEPTH(DEPTH)) dut (
    .i_clk         (i_clk),
    .i_rst         (i_rst),
    .i_clk_1       (i_clk_1),
    .i_clk_2       (i_clk_2),
    .i_clk_sampl   (i_clk_sampl),
    .i_enb         (i_enb),
    .out_if        (out_if),
    .o_output_last (o_output_last),
    .o_overflow    (o_overflow)
  );

  always #5 i_clk = ~i_clk;

  // consumer ready: fixed level, or a repeating 1-0-0-1 pattern
  logic       rdy_lvl = 1'b0;
  logic       bp_mode = 1'b0;
  logic [3:0] bp_pat  = 4'b1001;
  logic [1:0] bp_idx  = 2'd0;
  assign out_if.i_tready = bp_mode ? bp_pat[bp_idx] : rdy_lvl;
  always @(posedge i_clk) begin
    #1 bp_idx = bp_idx + 2'd1;
  end

  // monitor: sampled on the falling edge, between DUT updates
  logic [8:0] got_q[$];
  int         ol_count = 0, ol_cyc = 0, last_hs_cyc = 0, cyc_n = 0;
  int         stall_viol = 0, stall_cnt = 0;
  logic       prev_stall = 1'b0;
  logic [8:0] prev_ent = '0;
  always @(negedge i_clk) begin
    cyc_n = cyc_n + 1;
    if (prev_stall && !(out_if.o_tdata_valid &&
        {out_if.o_tdata_last, out_if.o_tdata} == prev_ent))
      stall_viol = stall_viol + 1;
    prev_stall = out_if.o_tdata_valid && !out_if.i_tready;
    if (prev_stall) stall_cnt = stall_cnt + 1;
    prev_ent = {out_if.o_tdata_last, out_if.o_tdata};
    if (out_if.o_tdata_valid && out_if.i_tready) begin
      got_q.push_back({out_if.o_tdata_last, out_if.o_tdata});
      if (out_if.o_tdata_last) last_hs_cyc = cyc_n;
    end
    if (o_output_last) begin
      ol_count = ol_count + 1;
      ol_cyc   = cyc_n;
    end
  end

  int n_cmp = 0;
  int n_mis = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp = n_cmp + 1;
    if (got !== exp) begin
      n_mis = n_mis + 1;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cyc(input logic en, input logic c2, input logic c1, input logic s);
    i_enb = en; i_clk_2 = c2; i_clk_1 = c1; i_clk_sampl = s;
    @(posedge i_clk); #1;
  endtask

  logic [8:0] exp_q[$];
  int         got_base, ol_base;

  task automatic begin_burst();
    got_base = got_q.size();
    ol_base  = ol_count;
    exp_q.delete();
  endtask

  task automatic finish_burst(input string name, input logic exp_ovf);
    int n = 0;
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
    while (ol_count == ol_base && n < 2000) begin
      @(posedge i_clk); #1;
      n++;
    end
    repeat (3) begin @(posedge i_clk); #1; end
    check({name, ":ol_count"}, ol_count - ol_base, 1);
    check({name, ":ol_delay"}, ol_cyc - last_hs_cyc, 1);
    check({name, ":n_bytes"}, got_q.size() - got_base, exp_q.size());
    for (int i = 0; i < exp_q.size() && got_base + i < got_q.size(); i++)
      check({name, ":byte"}, got_q[got_base + i], exp_q[i]);
    check({name, ":overflow"}, o_overflow, exp_ovf);
  endtask

  // {clk_2, clk_1}; clk_sampl follows clk_2
  logic [1:0] pat7 [7] = '{2'b01, 2'b00, 2'b01, 2'b10, 2'b00, 2'b01, 2'b11};

  task automatic basic_burst();
    for (int i = 0; i < 7; i++) cyc(1'b1, pat7[i][1], pat7[i][0], pat7[i][1]);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    int sv_base, sc_base;
    #1;
    check("rst:valid", out_if.o_tdata_valid, 0);
    check("rst:data", out_if.o_tdata, 0);
    check("rst:last", out_if.o_tdata_last, 0);
    check("rst:output_last", o_output_last, 0);
    check("rst:overflow", o_overflow, 0);
    repeat (3) @(posedge i_clk);
    #1 i_rst = 1'b0;

    // basic burst, always ready
    rdy_lvl = 1'b1;
    begin_burst();
    exp_q.push_back(9'h002); exp_q.push_back(9'h003); exp_q.push_back(9'h103);
    basic_burst();
    finish_burst("basic", 1'b0);

    // same burst under backpressure
    bp_mode = 1'b1;
    sv_base = stall_viol;
    sc_base = stall_cnt;
    begin_burst();
    exp_q.push_back(9'h002); exp_q.push_back(9'h003); exp_q.push_back(9'h103);
    basic_burst();
    finish_burst("bp", 1'b0);
    check("bp:stable", stall_viol - sv_base, 0);
    check("bp:stalled", (stall_cnt - sc_base) > 0, 1);
    bp_mode = 1'b0;

    // no captures, 5 clk_1 rises
    begin_burst();
    exp_q.push_back(9'h105);
    repeat (5) begin cyc(1'b1, 1'b0, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0, 1'b0); end
    finish_burst("empty", 1'b0);

    // 256 rises wrap the counter to zero
    begin_burst();
    exp_q.push_back(9'h100);
    repeat (256) begin cyc(1'b1, 1'b0, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0, 1'b0); end
    finish_burst("wrap", 1'b0);

    // DEPTH+3 captures of values 1..19 with the consumer stalled
    rdy_lvl = 1'b0;
    begin_burst();
    for (int k = 1; k <= DEPTH; k++) exp_q.push_back(9'(k));
    exp_q.push_back(9'h100 | 9'(DEPTH + 3));
    for (int k = 1; k <= DEPTH + 3; k++) begin
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b0, 1'b1);
    end
    repeat (6) cyc(1'b0, 1'b0, 1'b0, 1'b0);
    check("ovf:flag", o_overflow, 1);
    check("ovf:stall_valid", out_if.o_tdata_valid, 1);
    check("ovf:stall_head", out_if.o_tdata, 1);
    check("ovf:stall_last", out_if.o_tdata_last, 0);
    check("ovf:no_ol", ol_count - ol_base, 0);
    rdy_lvl = 1'b1;
    finish_burst("ovf", 1'b1);

    // clear sticky overflow
    i_rst = 1'b1;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    check("rst2:overflow", o_overflow, 0);

    // asynchronous reset in the middle of a burst
    rdy_lvl = 1'b0;
    ol_base  = ol_count;
    got_base = got_q.size();
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 1'b0);
    check("arst:pre_valid", out_if.o_tdata_valid, 1);
    #3 i_rst = 1'b1;
    #1;
    check("arst:valid", out_if.o_tdata_valid, 0);
    check("arst:data", out_if.o_tdata, 0);
    check("arst:last", out_if.o_tdata_last, 0);
    check("arst:output_last", o_output_last, 0);
    i_enb = 1'b0; i_clk_1 = 1'b0; i_clk_2 = 1'b0; i_clk_sampl = 1'b0;
    repeat (2) @(posedge i_clk);
    #1 i_rst = 1'b0;
    repeat (10) begin @(posedge i_clk); #1; end
    check("arst:no_ol", ol_count - ol_base, 0);
    check("arst:no_bytes", got_q.size() - got_base, 0);

    // following burst starts from A=0
    rdy_lvl = 1'b1;
    begin_burst();
    exp_q.push_back(9'h103);
    repeat (3) begin cyc(1'b1, 1'b0, 1'b1, 1'b0); cyc(1'b1, 1'b0, 1'b0, 1'b0); end
    finish_burst("post_rst", 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
